// File: rtl/pe_pkg.sv
// Shared widths and sequencer state encoding for the PE MAC datapath.
package pe_pkg;

  localparam int PE_A_W   = 8;
  localparam int PE_B_W   = 8;
  localparam int PE_ACC_W = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } pe_seq_state_t;

endpackage

// File: rtl/pe_mac_seq.sv
// Upstream sequencer for one PE MAC core: streams operand pairs into the PE,
// counts its completion pulses and captures the final accumulator value.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    vec_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PE_A_W-1:0]   in_a,
  input  logic [PE_B_W-1:0]   in_b,
  output logic                pe_read_in,
  output logic                pe_mode_sel,
  output logic                pe_clr_acc,
  output logic [PE_A_W-1:0]   pe_a_mul,
  output logic [PE_B_W-1:0]   pe_b_mul,
  input  logic                pe_out_vld,
  input  logic [PE_ACC_W-1:0] pe_acc_raw,
  output logic                busy,
  output logic                done,
  output logic [PE_ACC_W-1:0] result,
  output logic                result_valid,
  output logic [2:0]          dbg_state
);

  // Operand stream: a pair transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on the state, never on in_valid.

  pe_seq_state_t        state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]     vld_cnt_q, vld_cnt_d;
  logic [PE_A_W-1:0]    a_q, a_d;
  logic [PE_B_W-1:0]    b_q, b_d;
  logic                 read_q, read_d;
  logic                 mode_q, mode_d;
  logic                 abort_clr_q, abort_clr_d;
  logic [PE_ACC_W-1:0]  result_q, result_d;
  logic                 result_valid_q, result_valid_d;

  logic                 handshake;
  logic [LEN_W-1:0]     issue_inc;
  logic [LEN_W-1:0]     vld_inc;

  assign handshake = in_valid && (state_q == RUN);
  assign issue_inc = issue_cnt_q + LEN_W'(1);
  assign vld_inc   = vld_cnt_q + LEN_W'(1);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    issue_cnt_d    = issue_cnt_q;
    vld_cnt_d      = vld_cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    read_d         = 1'b0;
    mode_d         = mode_q;
    abort_clr_d    = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    if (abort) begin
      // Abort wins over everything; a coincident handshake is dropped.
      state_d        = IDLE;
      abort_clr_d    = 1'b1;
      result_d       = '0;
      result_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_d          = vec_len;
            issue_cnt_d    = '0;
            vld_cnt_d      = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
            state_d        = CLEAR;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            result_d       = '0;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            a_d         = in_a;
            b_d         = in_b;
            read_d      = 1'b1;
            mode_d      = (issue_cnt_q != '0);
            issue_cnt_d = issue_inc;
            if (issue_inc == len_q) begin
              state_d = DRAIN;
            end
          end
          if (pe_out_vld) begin
            vld_cnt_d = vld_inc;
          end
        end
        DRAIN: begin
          // The PE accumulator already reflects the last MAC when its pulse arrives.
          if (pe_out_vld) begin
            vld_cnt_d = vld_inc;
            if (vld_inc == len_q) begin
              result_d       = pe_acc_raw;
              result_valid_d = 1'b1;
              state_d        = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      issue_cnt_q    <= '0;
      vld_cnt_q      <= '0;
      a_q            <= '0;
      b_q            <= '0;
      read_q         <= 1'b0;
      mode_q         <= 1'b0;
      abort_clr_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      issue_cnt_q    <= issue_cnt_d;
      vld_cnt_q      <= vld_cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      read_q         <= read_d;
      mode_q         <= mode_d;
      abort_clr_q    <= abort_clr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign in_ready     = (state_q == RUN);
  assign pe_read_in   = read_q;
  assign pe_mode_sel  = mode_q;
  assign pe_clr_acc   = (state_q == CLEAR) || abort_clr_q;
  assign pe_a_mul     = a_q;
  assign pe_b_mul     = b_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE) && !abort;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign dbg_state    = state_q;

endmodule
